// File: rtl/riscvsys_pkg.sv
// ----------------------------------------------------------------------------
// riscvsys_pkg
// Shared definitions for the picorv32 memory-bus front-end and its helpers:
//   - busState_t       : states of the bus slave FSM
//   - CON_ADDR         : console byte port address
//   - CTRL_ADDR        : testbench-control word address
//   - CTRL_MAGIC       : upper 24 bits that mark a control word as genuine
//   - CTRL_PASS/FAIL/DUMP : control codes carried in the low byte
//   - xorshift32Next() : one step of the xorshift32 generator
// ----------------------------------------------------------------------------
package riscvsys_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } busState_t;

  localparam logic [31:0] CON_ADDR   = 32'h1000_0000;
  localparam logic [31:0] CTRL_ADDR  = 32'h2000_0000;

  localparam logic [23:0] CTRL_MAGIC = 24'hACCE55;

  localparam logic [7:0]  CTRL_PASS  = 8'h00;
  localparam logic [7:0]  CTRL_FAIL  = 8'h01;
  localparam logic [7:0]  CTRL_DUMP  = 8'h04;

  // One xorshift32 step. A non-zero input never produces zero, so any
  // non-zero seed keeps the sequence alive forever.
  function automatic logic [31:0] xorshift32Next(input logic [31:0] x);
    logic [31:0] s;
    s = x;
    s = s ^ (s << 13);
    s = s ^ (s >> 17);
    s = s ^ (s << 5);
    return s;
  endfunction

endpackage

// File: rtl/riscvsys_xorshift32.sv
// ----------------------------------------------------------------------------
// riscvsys_xorshift32
// Free-running xorshift32 pseudo-random generator used by stall inserters.
// Ports:
//   i_clk    in   1   clock
//   i_rst    in   1   asynchronous active-high reset (loads SEED)
//   o_state  out  32  current generator state
// Parameter:
//   SEED     reset value, must be non-zero
// ----------------------------------------------------------------------------
module riscvsys_xorshift32
  import riscvsys_pkg::*;
#(
  parameter logic [31:0] SEED = 32'd314159265
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  // The generator steps on every clock once reset is released, regardless
  // of what the consumer is doing, so its sequence depends only on time.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= SEED;
    end else begin
      r_state <= xorshift32Next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/riscvsys_membus.sv
// ----------------------------------------------------------------------------
// riscvsys_membus
// Slave front-end between the picorv32 native memory interface and a
// synchronous word RAM. Handles valid/ready, optional pseudo-random stalls,
// and decodes every access to RAM, console, control word or out-of-bounds.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_mem_valid         request valid from the core
//   i_mem_instr         instruction fetch flag (not needed for decode)
//   i_mem_addr  [31:0]  byte address
//   i_mem_wdata [31:0]  write data
//   i_mem_wstrb [3:0]   byte enables, zero means read
//   o_mem_ready         one-cycle completion strobe
//   o_mem_rdata [31:0]  read data, valid with o_mem_ready
//   o_ram_en            RAM access strobe
//   o_ram_we    [3:0]   RAM byte write enables
//   o_ram_addr          RAM word address
//   o_ram_wdata [31:0]  RAM write data
//   i_ram_rdata [31:0]  RAM read data, valid the cycle after a read strobe
//   o_con_valid         console byte strobe
//   o_con_data  [7:0]   console byte
//   o_ctrl_valid        control word strobe
//   o_ctrl_code [7:0]   control code
//   o_oob               sticky out-of-bounds flag
//   o_oob_addr  [31:0]  address of the first out-of-bounds access
// ----------------------------------------------------------------------------
module riscvsys_membus #(
  parameter int unsigned MEM_BYTES  = 65536,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [31:0] STALL_SEED = 32'd314159265,
  parameter logic [31:0] CON_ADDR   = riscvsys_pkg::CON_ADDR,
  parameter logic [31:0] CTRL_ADDR  = riscvsys_pkg::CTRL_ADDR
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_mem_valid,
  input  logic                           i_mem_instr,
  input  logic [31:0]                    i_mem_addr,
  input  logic [31:0]                    i_mem_wdata,
  input  logic [3:0]                     i_mem_wstrb,
  output logic                           o_mem_ready,
  output logic [31:0]                    o_mem_rdata,
  output logic                           o_ram_en,
  output logic [3:0]                     o_ram_we,
  output logic [$clog2(MEM_BYTES)-3:0]   o_ram_addr,
  output logic [31:0]                    o_ram_wdata,
  input  logic [31:0]                    i_ram_rdata,
  output logic                           o_con_valid,
  output logic [7:0]                     o_con_data,
  output logic                           o_ctrl_valid,
  output logic [7:0]                     o_ctrl_code,
  output logic                           o_oob,
  output logic [31:0]                    o_oob_addr
);

  import riscvsys_pkg::*;

  localparam int AW = $clog2(MEM_BYTES);

  busState_t   r_state;
  busState_t   w_stateNext;
  logic [31:0] r_rdata;
  logic        r_oob;
  logic [31:0] r_oobAddr;

  logic [31:0] w_prng;
  logic        w_stall;
  logic        w_accept;
  logic        w_isWrite;
  logic        w_isRam;
  logic        w_isCon;
  logic        w_isCtrl;
  logic        w_isOob;
  logic        w_ctrlMagic;
  logic        w_unused;

  riscvsys_xorshift32 #(
    .SEED (STALL_SEED)
  ) u_prng (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .o_state (w_prng)
  );

  // Address decode. The four targets are mutually exclusive; anything that
  // is neither RAM nor one of the two device words is out-of-bounds.
  assign w_isWrite   = |i_mem_wstrb;
  assign w_isRam     = (i_mem_addr < MEM_BYTES);
  assign w_isCon     = (i_mem_addr == CON_ADDR);
  assign w_isCtrl    = (i_mem_addr == CTRL_ADDR);
  assign w_isOob     = !w_isRam && !w_isCon && !w_isCtrl;
  assign w_ctrlMagic = (i_mem_wdata[31:8] == CTRL_MAGIC);

  // A stall cycle simply refuses the request; the core keeps valid high so
  // it is picked up on the first non-stall cycle. Reset gates acceptance so
  // no strobe can leak out while reset is held with valid still asserted.
  assign w_stall  = STALL_EN && !w_prng[0];
  assign w_accept = (r_state == IDLE) && i_mem_valid && !w_stall && !i_rst;

  assign o_ram_addr  = i_mem_addr[AW-1:2];
  assign o_ram_wdata = i_mem_wdata;
  assign o_con_data  = i_mem_wdata[7:0];
  assign o_ctrl_code = i_mem_wdata[7:0];
  assign o_mem_ready = (r_state == RESP);
  assign o_mem_rdata = r_rdata;
  assign o_oob       = r_oob;
  assign o_oob_addr  = r_oobAddr;

  // Instruction-fetch flag and the upper PRNG bits have no effect on this
  // slave; folding them here keeps them visibly intentional.
  assign w_unused = ^{i_mem_instr, w_prng[31:1]};

  // State register: a single transaction is tracked from acceptance through
  // the optional RAM wait cycle to the ready cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. Only RAM reads need the extra cycle for the
  // synchronous RAM to return data; everything else goes straight to RESP.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_isRam && !w_isWrite) begin
            w_stateNext = RD_WAIT;
          end else begin
            w_stateNext = RESP;
          end
        end
      end
      RD_WAIT: w_stateNext = RESP;
      RESP:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Event strobes fire combinationally in the accept cycle so the RAM sees
  // its access in the same cycle and console/control events are one cycle.
  always_comb begin
    o_ram_en     = 1'b0;
    o_ram_we     = 4'b0000;
    o_con_valid  = 1'b0;
    o_ctrl_valid = 1'b0;
    if (w_accept) begin
      if (w_isRam) begin
        o_ram_en = 1'b1;
        o_ram_we = i_mem_wstrb;
      end
      if (w_isCon && w_isWrite) begin
        o_con_valid = 1'b1;
      end
      if (w_isCtrl && w_isWrite && w_ctrlMagic) begin
        o_ctrl_valid = 1'b1;
      end
    end
  end

  // Read-data register: loaded from the RAM in the wait cycle, and forced
  // to zero on every accepted access that will not return RAM data, so
  // write and device responses always carry zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= 32'd0;
    end else if (r_state == RD_WAIT) begin
      r_rdata <= i_ram_rdata;
    end else if (w_accept && !(w_isRam && !w_isWrite)) begin
      r_rdata <= 32'd0;
    end
  end

  // Sticky out-of-bounds tracking: the flag stays until reset and the
  // address register keeps the first offender for post-mortem debugging.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_oob     <= 1'b0;
      r_oobAddr <= 32'd0;
    end else if (w_accept && w_isOob) begin
      r_oob <= 1'b1;
      if (!r_oob) begin
        r_oobAddr <= i_mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_riscvsys_membus.sv
// ----------------------------------------------------------------------------
// tb_riscvsys_membus
// Two instances of the bus front-end: dutA without stalls for the directed
// scenarios, dutB with stalls for a long randomized run whose latencies and
// read data are predicted from a transaction-level model.
// ----------------------------------------------------------------------------
module tb_riscvsys_membus;

  localparam int unsigned MEMB = 65536;
  localparam logic [31:0] SEED = 32'd314159265;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // dutA signals
  logic        aValid, aInstr;
  logic [31:0] aAddr, aWdata;
  logic [3:0]  aWstrb;
  logic        aReady;
  logic [31:0] aRdata;
  logic        aRamEn;
  logic [3:0]  aRamWe;
  logic [13:0] aRamAddr;
  logic [31:0] aRamWdata, aRamRdata;
  logic        aConValid, aCtrlValid, aOob;
  logic [7:0]  aConData, aCtrlCode;
  logic [31:0] aOobAddr;

  // dutB signals
  logic        bValid, bInstr;
  logic [31:0] bAddr, bWdata;
  logic [3:0]  bWstrb;
  logic        bReady;
  logic [31:0] bRdata;
  logic        bRamEn;
  logic [3:0]  bRamWe;
  logic [13:0] bRamAddr;
  logic [31:0] bRamWdata, bRamRdata;
  logic        bConValid, bCtrlValid, bOob;
  logic [7:0]  bConData, bCtrlCode;
  logic [31:0] bOobAddr;

  logic [31:0] ramA [0:16383];
  logic [31:0] ramB [0:16383];

  logic [31:0] prngModel;
  logic [31:0] refMem [0:63];

  riscvsys_membus #(.MEM_BYTES(MEMB), .STALL_EN(1'b0), .STALL_SEED(SEED)) dutA (
    .i_clk(clk), .i_rst(rst),
    .i_mem_valid(aValid), .i_mem_instr(aInstr), .i_mem_addr(aAddr),
    .i_mem_wdata(aWdata), .i_mem_wstrb(aWstrb),
    .o_mem_ready(aReady), .o_mem_rdata(aRdata),
    .o_ram_en(aRamEn), .o_ram_we(aRamWe), .o_ram_addr(aRamAddr),
    .o_ram_wdata(aRamWdata), .i_ram_rdata(aRamRdata),
    .o_con_valid(aConValid), .o_con_data(aConData),
    .o_ctrl_valid(aCtrlValid), .o_ctrl_code(aCtrlCode),
    .o_oob(aOob), .o_oob_addr(aOobAddr)
  );

  riscvsys_membus #(.MEM_BYTES(MEMB), .STALL_EN(1'b1), .STALL_SEED(SEED)) dutB (
    .i_clk(clk), .i_rst(rst),
    .i_mem_valid(bValid), .i_mem_instr(bInstr), .i_mem_addr(bAddr),
    .i_mem_wdata(bWdata), .i_mem_wstrb(bWstrb),
    .o_mem_ready(bReady), .o_mem_rdata(bRdata),
    .o_ram_en(bRamEn), .o_ram_we(bRamWe), .o_ram_addr(bRamAddr),
    .o_ram_wdata(bRamWdata), .i_ram_rdata(bRamRdata),
    .o_con_valid(bConValid), .o_con_data(bConData),
    .o_ctrl_valid(bCtrlValid), .o_ctrl_code(bCtrlCode),
    .o_oob(bOob), .o_oob_addr(bOobAddr)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous word RAM behind each instance: byte-masked write, data of
  // the addressed word (pre-write) presented the following cycle.
  always @(posedge clk) begin
    if (aRamEn) begin
      for (int b = 0; b < 4; b++)
        if (aRamWe[b]) ramA[aRamAddr][8*b +: 8] <= aRamWdata[8*b +: 8];
      aRamRdata <= ramA[aRamAddr];
    end
    if (bRamEn) begin
      for (int b = 0; b < 4; b++)
        if (bRamWe[b]) ramB[bRamAddr][8*b +: 8] <= bRamWdata[8*b +: 8];
      bRamRdata <= ramB[bRamAddr];
    end
  end

  function automatic logic [31:0] prngStep(input logic [31:0] x);
    logic [31:0] s;
    s = x ^ (x << 13);
    s = s ^ (s >> 17);
    s = s ^ (s << 5);
    return s;
  endfunction

  // Reference generator: one step per clock outside reset, seed in reset.
  always @(posedge clk or posedge rst) begin
    if (rst) prngModel = SEED;
    else     prngModel = prngStep(prngModel);
  end

  // From the generator value in the first request cycle, count the cycles
  // refused as stalls, then add the fixed service time of the access.
  function automatic int expectedLatency(input logic [31:0] x, input bit ramRead);
    int stalls;
    logic [31:0] s;
    stalls = 0;
    s = x;
    while (s[0] == 1'b0 && stalls < 64) begin
      s = prngStep(s);
      stalls++;
    end
    return stalls + (ramRead ? 2 : 1);
  endfunction

  function automatic int stallCount(input logic [31:0] x);
    return expectedLatency(x, 1'b0) - 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One transaction on dutA: present the request, watch strobes in the
  // first cycle, count event pulses, and record latency and read data.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb,
                               output int lat, output logic [31:0] rdata,
                               output logic en0, output logic [3:0] we0,
                               output logic [13:0] ramAddr0,
                               output int conCount, output logic [7:0] conData,
                               output int ctrlCount, output logic [7:0] ctrlCode);
    @(posedge clk);
    #1;
    aAddr = addr; aWdata = wdata; aWstrb = wstrb; aValid = 1'b1;
    lat = -1; rdata = 32'hxxxxxxxx; conCount = 0; ctrlCount = 0;
    en0 = 1'b0; we0 = 4'b0; ramAddr0 = 14'd0; conData = 8'd0; ctrlCode = 8'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        en0 = aRamEn; we0 = aRamWe; ramAddr0 = aRamAddr;
      end
      if (aConValid) begin conCount++; conData = aConData; end
      if (aCtrlValid) begin ctrlCount++; ctrlCode = aCtrlCode; end
      if (aReady) begin
        lat = k;
        rdata = aRdata;
        break;
      end
    end
    aValid = 1'b0;
  endtask

  // One transaction on dutB: same shape, with the expected latency taken
  // from the reference generator at the first request cycle.
  task automatic runStalled(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb,
                            output int lat, output int expLat,
                            output logic [31:0] rdata);
    @(posedge clk);
    #1;
    bAddr = addr; bWdata = wdata; bWstrb = wstrb; bValid = 1'b1;
    expLat = expectedLatency(prngModel, (addr < MEMB) && (wstrb == 4'b0));
    lat = -1; rdata = 32'hxxxxxxxx;
    for (int k = 0; k < expLat + 20; k++) begin
      @(negedge clk);
      if (bReady) begin
        lat = k;
        rdata = bRdata;
        break;
      end
    end
    bValid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int lat, expLat, conCount, ctrlCount, readyCount;
    logic [31:0] rd, addr, wdata, expRd, expOobAddr;
    logic [3:0] wstrb, we0;
    logic en0, expOob;
    logic [13:0] ra0;
    logic [7:0] conData, ctrlCode;
    int word, kind, stalls;

    rst = 1'b1;
    aValid = 0; aInstr = 0; aAddr = 0; aWdata = 0; aWstrb = 0;
    bValid = 0; bInstr = 0; bAddr = 0; bWdata = 0; bWstrb = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_ready", {31'd0, aReady}, 32'd0);
    checkOutput("rst_rdata", aRdata, 32'd0);
    checkOutput("rst_oob", {31'd0, aOob}, 32'd0);
    checkOutput("rst_oob_addr", aOobAddr, 32'd0);
    checkOutput("rst_strobes", {29'd0, aRamEn, aConValid, aCtrlValid}, 32'd0);

    $display("[TB] RAM write/read");
    applyStimulus(32'h100, 32'hDEADBEEF, 4'hF, lat, rd, en0, we0, ra0, conCount, conData, ctrlCount, ctrlCode);
    checkOutput("wr_lat", lat, 1);
    checkOutput("wr_en", {31'd0, en0}, 32'd1);
    checkOutput("wr_we", {28'd0, we0}, 32'hF);
    checkOutput("wr_addr", {18'd0, ra0}, 32'h40);
    checkOutput("wr_rdata", rd, 32'd0);
    applyStimulus(32'h100, 32'd0, 4'h0, lat, rd, en0, we0, ra0, conCount, conData, ctrlCount, ctrlCode);
    checkOutput("rd_lat", lat, 2);
    checkOutput("rd_data", rd, 32'hDEADBEEF);
    checkOutput("rd_addr", {18'd0, ra0}, 32'h40);
    checkOutput("rd_we", {28'd0, we0}, 32'h0);

    $display("[TB] byte write");
    applyStimulus(32'h101, 32'h0000AA00, 4'b0010, lat, rd, en0, we0, ra0, conCount, conData, ctrlCount, ctrlCode);
    checkOutput("bw_we", {28'd0, we0}, 32'h2);
    checkOutput("bw_addr", {18'd0, ra0}, 32'h40);
    checkOutput("bw_rdata_zero", rd, 32'd0);
    applyStimulus(32'h100, 32'd0, 4'h0, lat, rd, en0, we0, ra0, conCount, conData, ctrlCount, ctrlCode);
    checkOutput("bw_read", rd, 32'hDEADAAEF);

    $display("[TB] console");
    applyStimulus(32'h1000_0000, 32'h41, 4'hF, lat, rd, en0, we0, ra0, conCount, conData, ctrlCount, ctrlCode);
    checkOutput("con_lat", lat, 1);
    checkOutput("con_count", conCount, 1);
    checkOutput("con_data", {24'd0, conData}, 32'h41);
    checkOutput("con_no_ram", {31'd0, en0}, 32'd0);
    applyStimulus(32'h1000_0000, 32'd0, 4'h0, lat, rd, en0, we0, ra0, conCount, conData, ctrlCount, ctrlCode);
    checkOutput("con_rd_lat", lat, 1);
    checkOutput("con_rd_data", rd, 32'd0);
    checkOutput("con_rd_nostrobe", conCount, 0);

    $display("[TB] control");
    applyStimulus(32'h2000_0000, 32'hACCE5500, 4'hF, lat, rd, en0, we0, ra0, conCount, conData, ctrlCount, ctrlCode);
    checkOutput("ctrl_lat", lat, 1);
    checkOutput("ctrl_count", ctrlCount, 1);
    checkOutput("ctrl_code", {24'd0, ctrlCode}, 32'h00);
    applyStimulus(32'h2000_0000, 32'h12345678, 4'hF, lat, rd, en0, we0, ra0, conCount, conData, ctrlCount, ctrlCode);
    checkOutput("ctrl_bad_lat", lat, 1);
    checkOutput("ctrl_bad_count", ctrlCount, 0);

    $display("[TB] out-of-bounds");
    applyStimulus(32'h3000_0000, 32'h55, 4'hF, lat, rd, en0, we0, ra0, conCount, conData, ctrlCount, ctrlCode);
    checkOutput("oob_lat", lat, 1);
    @(negedge clk);
    checkOutput("oob_flag", {31'd0, aOob}, 32'd1);
    checkOutput("oob_addr", aOobAddr, 32'h3000_0000);
    applyStimulus(32'h0001_0000, 32'd0, 4'h0, lat, rd, en0, we0, ra0, conCount, conData, ctrlCount, ctrlCode);
    checkOutput("oob_rd_lat", lat, 1);
    checkOutput("oob_rd_data", rd, 32'd0);
    checkOutput("oob_rd_no_ram", {31'd0, en0}, 32'd0);
    checkOutput("oob_addr_kept", aOobAddr, 32'h3000_0000);
    applyStimulus(32'hFFFC, 32'd0, 4'h0, lat, rd, en0, we0, ra0, conCount, conData, ctrlCount, ctrlCode);
    checkOutput("top_word_lat", lat, 2);
    checkOutput("top_word_addr", {18'd0, ra0}, 32'h3FFF);
    checkOutput("oob_sticky", {31'd0, aOob}, 32'd1);

    $display("[TB] stalled random run");
    expOob = 1'b0;
    expOobAddr = 32'd0;
    for (int w = 0; w < 64; w++) begin
      wdata = $urandom;
      refMem[w] = wdata;
      runStalled(w * 4, wdata, 4'hF, lat, expLat, rd);
      checkOutput("init_lat", lat, expLat);
      checkOutput("init_rdata", rd, 32'd0);
    end
    for (int n = 64; n < 1000; n++) begin
      kind = $urandom_range(0, 9);
      word = $urandom_range(0, 63);
      wdata = $urandom;
      wstrb = 4'h0;
      addr = {word[23:0], 2'b00} | {30'd0, 2'($urandom_range(0, 3))};
      expRd = 32'd0;
      if (kind <= 3) begin
        expRd = refMem[word];
      end else if (kind <= 6) begin
        wstrb = 4'($urandom_range(1, 15));
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) refMem[word][8*b +: 8] = wdata[8*b +: 8];
      end else if (kind == 7) begin
        addr = 32'h1000_0000;
        wstrb = 4'h1;
      end else if (kind == 8) begin
        addr = 32'h2000_0000;
        wstrb = 4'hF;
        if ($urandom_range(0, 1) == 1) wdata = {24'hACCE55, wdata[7:0]};
      end else begin
        addr = ($urandom_range(0, 1) == 1) ? 32'h0001_0000 : (32'h4000_0000 | $urandom_range(0, 255));
        wstrb = 4'($urandom_range(0, 1) * 15);
        if (!expOob) begin
          expOob = 1'b1;
          expOobAddr = addr;
        end
      end
      runStalled(addr, wdata, wstrb, lat, expLat, rd);
      checkOutput("rand_lat", lat, expLat);
      checkOutput("rand_rdata", rd, expRd);
    end

    runStalled(32'h5000_0000, 32'd0, 4'h0, lat, expLat, rd);
    checkOutput("b_oob_lat", lat, expLat);
    if (!expOob) begin
      expOob = 1'b1;
      expOobAddr = 32'h5000_0000;
    end
    @(negedge clk);
    checkOutput("b_oob_flag", {31'd0, bOob}, {31'd0, expOob});
    checkOutput("b_oob_addr", bOobAddr, expOobAddr);

    $display("[TB] reset during read wait");
    refMem[0] = refMem[0] | 32'h0000_0001;
    runStalled(32'h0, refMem[0], 4'hF, lat, expLat, rd);
    checkOutput("pre_wr_lat", lat, expLat);
    runStalled(32'h0, 32'd0, 4'h0, lat, expLat, rd);
    checkOutput("pre_rd_data", rd, refMem[0]);
    @(posedge clk);
    #1;
    bAddr = 32'h4; bWdata = 32'd0; bWstrb = 4'h0; bValid = 1'b1;
    stalls = stallCount(prngModel);
    repeat (stalls + 1) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_ready", {31'd0, bReady}, 32'd0);
    checkOutput("mid_rst_rdata", bRdata, 32'd0);
    checkOutput("mid_rst_oob", {31'd0, bOob}, 32'd0);
    checkOutput("mid_rst_oob_addr", bOobAddr, 32'd0);
    checkOutput("mid_rst_strobes", {29'd0, bRamEn, bConValid, bCtrlValid}, 32'd0);
    @(posedge clk);
    #1;
    bValid = 1'b0;
    rst = 1'b0;
    readyCount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bReady) readyCount++;
    end
    checkOutput("mid_rst_no_ready", readyCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
